// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic functional unit: default lane widths and
// the add/sub op encoding used on add_sub.
package arith_pkg;
  localparam int IN_WIDTH_DEF = 8;
  localparam int WIDTH_DEF    = 16;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit add/subtract; o_carry is the carry-out on add and
// the unsigned borrow (i_a < i_b) on subtract. Zero latency, no flow control.
module addsub_core
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_carry
);

  logic [WIDTH:0] w_ext;

  // Extending by one bit makes bit WIDTH the carry on add and the borrow on
  // subtract, since the difference goes negative exactly when i_a < i_b.
  always_comb begin
    w_ext = '0;
    if (i_op == SUB) begin
      w_ext = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      w_ext = {1'b0, i_a} + {1'b0, i_b};
    end
  end

  assign o_res   = w_ext[WIDTH-1:0];
  assign o_carry = w_ext[WIDTH];

endmodule

// File: rtl/arith_fu.sv
// Registered multiplier and add/sub lanes, each with a sticky done flag.
// 1-cycle latency per lane; no backpressure, a start is accepted every cycle.
module arith_fu
  import arith_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mul_start,
  input  logic [IN_WIDTH-1:0]   mul_in1,
  input  logic [IN_WIDTH-1:0]   mul_in2,
  output logic [2*IN_WIDTH-1:0] mul_out,
  output logic                  mul_done,
  input  logic                  as_start,
  input  logic                  add_sub,
  input  logic [WIDTH-1:0]      as_in1,
  input  logic [WIDTH-1:0]      as_in2,
  output logic [WIDTH-1:0]      as_out,
  output logic                  as_carry,
  output logic                  as_done
);

  logic [2*IN_WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]      w_as_res;
  logic                  w_as_carry;

  logic [2*IN_WIDTH-1:0] r_mul_out;
  logic                  r_mul_done;
  logic [WIDTH-1:0]      r_as_out;
  logic                  r_as_carry;
  logic                  r_as_done;

  // Full-width operands so the product never truncates.
  assign w_prod = {{IN_WIDTH{1'b0}}, mul_in1} * {{IN_WIDTH{1'b0}}, mul_in2};

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .i_op    (add_sub),
    .i_a     (as_in1),
    .i_b     (as_in2),
    .o_res   (w_as_res),
    .o_carry (w_as_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mul_out  <= '0;
      r_mul_done <= 1'b0;
      r_as_out   <= '0;
      r_as_carry <= 1'b0;
      r_as_done  <= 1'b0;
    end else begin
      if (mul_start) begin
        r_mul_out  <= w_prod;
        r_mul_done <= 1'b1;
      end
      if (as_start) begin
        r_as_out   <= w_as_res;
        r_as_carry <= w_as_carry;
        r_as_done  <= 1'b1;
      end
    end
  end

  assign mul_out  = r_mul_out;
  assign mul_done = r_mul_done;
  assign as_out   = r_as_out;
  assign as_carry = r_as_carry;
  assign as_done  = r_as_done;

endmodule

// File: tb/tb_arith_fu.sv
// Self-checking bench for arith_fu: directed cases plus randomized traffic
// compared against an integer-arithmetic reference model.
module tb_arith_fu;
  localparam int IN_WIDTH = 8;
  localparam int WIDTH    = 16;

  logic                  clk;
  logic                  reset;
  logic                  mul_start;
  logic [IN_WIDTH-1:0]   mul_in1;
  logic [IN_WIDTH-1:0]   mul_in2;
  logic [2*IN_WIDTH-1:0] mul_out;
  logic                  mul_done;
  logic                  as_start;
  logic                  add_sub;
  logic [WIDTH-1:0]      as_in1;
  logic [WIDTH-1:0]      as_in2;
  logic [WIDTH-1:0]      as_out;
  logic                  as_carry;
  logic                  as_done;

  int n_chk;
  int n_fail;

  // Reference model state
  longint exp_mul_out;
  int     exp_mul_done;
  longint exp_as_out;
  int     exp_as_carry;
  int     exp_as_done;

  arith_fu #(
    .IN_WIDTH (IN_WIDTH),
    .WIDTH    (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mul_start (mul_start),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .mul_done  (mul_done),
    .as_start  (as_start),
    .add_sub   (add_sub),
    .as_in1    (as_in1),
    .as_in2    (as_in2),
    .as_out    (as_out),
    .as_carry  (as_carry),
    .as_done   (as_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), advance the model by the
  // rules of the unit, then compare all outputs at the following negedge.
  task automatic cyc(input logic rst,
                     input logic ms, input int a1, input int a2,
                     input logic as, input logic op, input int b1, input int b2,
                     input string tag);
    longint sum;
    reset     = rst;
    mul_start = ms;
    mul_in1   = IN_WIDTH'(a1);
    mul_in2   = IN_WIDTH'(a2);
    as_start  = as;
    add_sub   = op;
    as_in1    = WIDTH'(b1);
    as_in2    = WIDTH'(b2);
    if (rst) begin
      exp_mul_out = 0; exp_mul_done = 0;
      exp_as_out  = 0; exp_as_carry = 0; exp_as_done = 0;
    end else begin
      if (ms) begin
        exp_mul_out  = longint'(a1 % 256) * longint'(a2 % 256);
        exp_mul_done = 1;
      end
      if (as) begin
        if (op) begin
          sum          = longint'(b1) - longint'(b2);
          exp_as_carry = (b1 < b2) ? 1 : 0;
          exp_as_out   = (sum + 65536) % 65536;
        end else begin
          sum          = longint'(b1) + longint'(b2);
          exp_as_carry = (sum >= 65536) ? 1 : 0;
          exp_as_out   = sum % 65536;
        end
        exp_as_done = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".mul_out"},  longint'(mul_out),  exp_mul_out);
    chk({tag, ".mul_done"}, longint'(mul_done), longint'(exp_mul_done));
    chk({tag, ".as_out"},   longint'(as_out),   exp_as_out);
    chk({tag, ".as_carry"}, longint'(as_carry), longint'(exp_as_carry));
    chk({tag, ".as_done"},  longint'(as_done),  longint'(exp_as_done));
  endtask

  task automatic idle(input string tag);
    // Scribble on operands to show they are ignored without a start.
    cyc(1'b0, 1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
        1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)),
        int'($urandom_range(0, 65535)), tag);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1; mul_start = 1'b0; as_start = 1'b0; add_sub = 1'b0;
    mul_in1 = '0; mul_in2 = '0; as_in1 = '0; as_in2 = '0;
    @(negedge clk);

    // Reset wins over simultaneous starts
    cyc(1'b1, 1'b1, 200, 200, 1'b1, 1'b0, 60000, 60000, "rst0");
    cyc(1'b1, 1'b1, 17, 3, 1'b1, 1'b1, 1, 2, "rst1");
    chk("rst_mul_out_zero", longint'(mul_out), 0);

    // Basic multiply, then held for 5 idle cycles
    cyc(1'b0, 1'b1, 5, 3, 1'b0, 1'b0, 0, 0, "mul5x3");
    chk("mul5x3_const", longint'(mul_out), 15);
    chk("as_done_still_low", longint'(as_done), 0);
    for (int i = 0; i < 5; i++) idle("mul_hold");
    chk("mul_hold_const", longint'(mul_out), 15);

    // Concurrent lanes
    cyc(1'b0, 1'b1, 4, 6, 1'b1, 1'b0, 7, 3, "concur");
    chk("concur_mul", longint'(mul_out), 24);
    chk("concur_as", longint'(as_out), 10);

    // Borrow and add wrap
    cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 10, 25, "borrow");
    chk("borrow_val", longint'(as_out), 64'hFFF1);
    chk("borrow_flag", longint'(as_carry), 1);
    cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 65535, 1, "wrap");
    chk("wrap_val", longint'(as_out), 0);
    chk("wrap_carry", longint'(as_carry), 1);
    cyc(1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 25, 25, "sub_eq");

    // Extremes and back-to-back starts
    cyc(1'b0, 1'b1, 255, 255, 1'b0, 1'b0, 0, 0, "mul_max");
    chk("mul_max_const", longint'(mul_out), 64'hFE01);
    cyc(1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 0, 0, "b2b_0");
    chk("b2b_four", longint'(mul_out), 4);
    cyc(1'b0, 1'b1, 3, 3, 1'b0, 1'b0, 0, 0, "b2b_1");
    chk("b2b_nine", longint'(mul_out), 9);

    // Reset right after a start: nothing stale survives
    cyc(1'b0, 1'b1, 9, 9, 1'b1, 1'b0, 100, 200, "pre_rst");
    cyc(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 0, "mid_rst");
    chk("mid_rst_mul_done", longint'(mul_done), 0);
    for (int i = 0; i < 3; i++) idle("post_rst");
    chk("post_rst_no81", longint'(mul_out), 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
